// File: rtl/pcf_pkg.sv
// Shared types and helpers for the streaming frame peak/centre finder.
// State encoding and index-width helper used by the top and the tracker.
package pcf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pcf_state_e;

    function automatic int pcf_idx_w(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/peak_center_finder_if.sv
// Sample-in / result-out bundle of the peak centre finder.
// PCF_THRESH_EN adds the thresh input and found output.
interface peak_center_finder_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 9
);

    logic [DATA_W-1:0] idata;
    logic              en_in;
    logic              sof;
    logic [DATA_W-1:0] max_data;
    logic [IDX_W-1:0]  max_id;
    logic [IDX_W-1:0]  cent_id;
    logic [IDX_W:0]    max_cnt;
    logic              en_out;
`ifdef PCF_THRESH_EN
    logic [DATA_W-1:0] thresh;
    logic              found;

    modport master (
        output idata, en_in, sof, thresh,
        input  max_data, max_id, cent_id, max_cnt, en_out, found
    );

    modport slave (
        input  idata, en_in, sof, thresh,
        output max_data, max_id, cent_id, max_cnt, en_out, found
    );
`else
    modport master (
        output idata, en_in, sof,
        input  max_data, max_id, cent_id, max_cnt, en_out
    );

    modport slave (
        input  idata, en_in, sof,
        output max_data, max_id, cent_id, max_cnt, en_out
    );
`endif

endinterface

// File: rtl/pcf_track.sv
// Compare/update datapath: running peak, first/last peak index, tie count.
// The nxt_* values include the current sample so the top can latch them.
module pcf_track
    import pcf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              start,
    input  logic              hit,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] nxt_max,
    output logic [IDX_W-1:0]  nxt_first,
    output logic [IDX_W-1:0]  nxt_last,
    output logic [IDX_W:0]    nxt_count,
    output logic              nxt_any
);

    logic [DATA_W-1:0] cur_max;
    logic [IDX_W-1:0]  first;
    logic [IDX_W-1:0]  last;
    logic [IDX_W:0]    count;
    logic              any_q;

    logic [DATA_W-1:0] b_max;
    logic              b_any;

    // index 0 starts from an empty frame, whatever the registers hold
    always_comb begin
        b_any     = start ? 1'b0 : any_q;
        b_max     = start ? '0 : cur_max;
        nxt_any   = b_any;
        nxt_max   = b_max;
        nxt_first = start ? '0 : first;
        nxt_last  = start ? '0 : last;
        nxt_count = start ? '0 : count;
        if (hit) begin
            if (!b_any || data > b_max) begin
                nxt_any   = 1'b1;
                nxt_max   = data;
                nxt_first = idx;
                nxt_last  = idx;
                nxt_count = (IDX_W+1)'(1);
            end else if (data == b_max) begin
                nxt_last  = idx;
                nxt_count = count + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_max <= '0;
            first   <= '0;
            last    <= '0;
            count   <= '0;
            any_q   <= 1'b0;
        end else if (en) begin
            cur_max <= nxt_max;
            first   <= nxt_first;
            last    <= nxt_last;
            count   <= nxt_count;
            any_q   <= nxt_any;
        end
    end

endmodule

// File: rtl/peak_center_finder.sv
// Streaming frame peak locator: peak value, first index, span centre, count.
// Optional PCF_THRESH_EN: per-frame qualification threshold and found flag.
module peak_center_finder
    import pcf_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 512
) (
    input logic                clk,
    input logic                rstn,
    peak_center_finder_if.slave bus
);

    localparam int IDX_W = pcf_idx_w(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    pcf_state_e state, state_n;

    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              start;
    logic              fin;
    logic              hit;

    logic [DATA_W-1:0] nxt_max;
    logic [IDX_W-1:0]  nxt_first;
    logic [IDX_W-1:0]  nxt_last;
    logic [IDX_W:0]    nxt_count;
    logic              nxt_any;
    logic [IDX_W:0]    span_sum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.en_in) state_n = fin ? IDLE : ACC;
    end

    // sof outranks the last-index check, so a restart never emits a result
    always_comb begin
        start = bus.en_in && (state == IDLE || bus.sof);
        idx   = start ? '0 : cnt;
        fin   = bus.en_in && (idx == LAST_IDX);
    end

`ifdef PCF_THRESH_EN
    logic [DATA_W-1:0] thr_q;
    logic [DATA_W-1:0] thr_eff;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      thr_q <= '0;
        else if (start) thr_q <= bus.thresh;
    end

    assign thr_eff = start ? bus.thresh : thr_q;
    assign hit     = bus.en_in && (bus.idata >= thr_eff);
`else
    assign hit = bus.en_in;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           cnt <= '0;
        else if (bus.en_in)  cnt <= fin ? '0 : idx + IDX_W'(1);
    end

    pcf_track #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_track (
        .clk       (clk),
        .rstn      (rstn),
        .en        (bus.en_in),
        .start     (start),
        .hit       (hit),
        .idx       (idx),
        .data      (bus.idata),
        .nxt_max   (nxt_max),
        .nxt_first (nxt_first),
        .nxt_last  (nxt_last),
        .nxt_count (nxt_count),
        .nxt_any   (nxt_any)
    );

    assign span_sum = {1'b0, nxt_first} + {1'b0, nxt_last};

    // a frame with no qualifying sample reports all zeros
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.en_out   <= 1'b0;
            bus.max_data <= '0;
            bus.max_id   <= '0;
            bus.cent_id  <= '0;
            bus.max_cnt  <= '0;
        end else begin
            bus.en_out <= fin;
            if (fin) begin
                bus.max_data <= nxt_any ? nxt_max : '0;
                bus.max_id   <= nxt_any ? nxt_first : '0;
                bus.cent_id  <= nxt_any ? span_sum[IDX_W:1] : '0;
                bus.max_cnt  <= nxt_any ? nxt_count : '0;
            end
        end
    end

`ifdef PCF_THRESH_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    bus.found <= 1'b0;
        else if (fin) bus.found <= nxt_any;
    end
`endif

endmodule
